// File: rtl/shreg_rr.sv
// -----------------------------------------------------------------------------
// shreg_rr -- shared W-bit register, round-robin arbitrated writers
//
// N independent requesters write one shared register over 4-phase req/ack
// handshakes. At most one write lands per clock. The grant goes to the first
// pending requester found searching from the round-robin pointer upward,
// wrapping modulo N. After a grant the pointer moves just past the winner, so
// every other requester is visited before the winner is considered again.
//
// Ports:
//   clk  in   1     system clock, rising edge
//   res  in   1     synchronous active-high reset
//   req  in   N     per-requester write request (level, 4-phase)
//   d    in   N*W   write data, requester i at d[i*W +: W]
//   q    out  W     current register value
//   ack  out  N     per-requester acknowledge
//   upd  out  1     one-cycle pulse the cycle after q was written
//   src  out  SW    index of the requester that made the most recent write
// -----------------------------------------------------------------------------
module shreg_rr #(
    parameter int           N    = 4,
    parameter int           W    = 8,
    parameter logic [W-1:0] INIT = {W{1'b0}},
    parameter int           SW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            res,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  d,
    output logic [W-1:0]    q,
    output logic [N-1:0]    ack,
    output logic            upd,
    output logic [SW-1:0]   src
);

    logic [W-1:0]  q_r;
    logic [N-1:0]  ack_r;
    logic          upd_r;
    logic [SW-1:0] src_r;
    logic [SW-1:0] ptr_r;

    logic [N-1:0]  pend_s;
    logic          grant_valid_s;
    logic [SW-1:0] grant_idx_s;
    logic [SW:0]   cand_s;
    logic [N-1:0]  grant_vec_s;
    logic [N-1:0]  ack_next_s;
    logic [SW-1:0] ptr_next_s;
    logic [W-1:0]  wdata_s;

    // A requester is pending only until its ack has been registered.
    assign pend_s = req & ~ack_r;

    // Round-robin search starting at ptr; the candidate index is one bit wider
    // than ptr so ptr+k cannot overflow before the explicit wrap at N.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {SW{1'b0}};
        cand_s        = {(SW+1){1'b0}};
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr_r} + (SW+1)'(k);
            if (cand_s >= (SW+1)'(N)) begin
                cand_s = cand_s - (SW+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_valid_s && pend_s[cand_s[SW-1:0]]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = cand_s[SW-1:0];
            end else begin
                grant_valid_s = grant_valid_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // One-hot grant, next ack vector (release on req low, set on grant) and
    // the pointer position just past the winner, wrapping from N-1 to 0.
    always_comb begin
        grant_vec_s = {N{1'b0}};
        ptr_next_s  = ptr_r;
        if (grant_valid_s) begin
            grant_vec_s[grant_idx_s] = 1'b1;
            if (grant_idx_s == SW'(N-1)) begin
                ptr_next_s = {SW{1'b0}};
            end else begin
                ptr_next_s = grant_idx_s + SW'(1);
            end
        end else begin
            grant_vec_s = {N{1'b0}};
            ptr_next_s  = ptr_r;
        end
        ack_next_s = (ack_r & req) | grant_vec_s;
    end

    // Data of the granted requester; only meaningful when grant_valid_s.
    always_comb begin
        wdata_s = d[int'(grant_idx_s)*W +: W];
    end

    // State and output registers; reset overrides any grant on the same edge.
    always_ff @(posedge clk) begin
        if (res) begin
            q_r   <= INIT;
            ack_r <= {N{1'b0}};
            upd_r <= 1'b0;
            src_r <= {SW{1'b0}};
            ptr_r <= {SW{1'b0}};
        end else begin
            ack_r <= ack_next_s;
            upd_r <= grant_valid_s;
            if (grant_valid_s) begin
                q_r   <= wdata_s;
                src_r <= grant_idx_s;
                ptr_r <= ptr_next_s;
            end else begin
                q_r   <= q_r;
                src_r <= src_r;
                ptr_r <= ptr_r;
            end
        end
    end

    assign q   = q_r;
    assign ack = ack_r;
    assign upd = upd_r;
    assign src = src_r;

endmodule

// File: tb/tb_shreg_rr.sv
// -----------------------------------------------------------------------------
// tb_shreg_rr -- self-checking bench for shreg_rr (N=4, W=8, INIT=8'hA5)
//
// A behavioural model (integer pointer, modulo search, bit arrays) tracks the
// expected register, ack vector, strobe and source after every rising edge.
// Directed scenarios cover reset, single write, full contention, fairness,
// withdrawal and reset mid-transaction; a randomized phase follows with
// protocol-obeying requesters and occasional resets.
// -----------------------------------------------------------------------------
module tb_shreg_rr;

    localparam int N = 4;
    localparam int W = 8;
    localparam logic [W-1:0] INIT = 8'hA5;

    logic         clk;
    logic         res;
    logic [N-1:0] req;
    logic [N*W-1:0] d;
    logic [W-1:0] q;
    logic [N-1:0] ack;
    logic         upd;
    logic [1:0]   src;

    int n_vec;
    int n_err;

    // reference model state
    int          m_ptr;
    logic [3:0]  m_ack;
    logic [7:0]  m_q;
    int          m_src;
    logic        m_upd;
    int          last_grant;

    shreg_rr #(.N(N), .W(W), .INIT(INIT)) dut (
        .clk (clk),
        .res (res),
        .req (req),
        .d   (d),
        .q   (q),
        .ack (ack),
        .upd (upd),
        .src (src)
    );

    // free-running clock, 10 time units period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // model of one rising edge, using the inputs as they were at that edge
    task automatic model_edge(input logic r, input logic [3:0] rq, input logic [31:0] dd);
        logic [3:0] pend;
        logic [3:0] nack;
        int g;
        if (r) begin
            m_q = INIT; m_ack = 4'b0000; m_upd = 1'b0; m_src = 0; m_ptr = 0;
            last_grant = -1;
        end else begin
            pend = rq & ~m_ack;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            nack = m_ack & rq;
            if (g >= 0) begin
                m_q = dd[g*8 +: 8];
                nack[g] = 1'b1;
                m_src = g;
                m_ptr = (g + 1) % N;
                m_upd = 1'b1;
            end else begin
                m_upd = 1'b0;
            end
            last_grant = g;
            m_ack = nack;
        end
    endtask

    // advance one edge, update model, compare all outputs shortly after
    task automatic tick();
        logic       r_s;
        logic [3:0] rq_s;
        logic [31:0] d_s;
        r_s = res; rq_s = req; d_s = d;
        @(posedge clk);
        model_edge(r_s, rq_s, d_s);
        #1;
        check("q",   {24'd0, q},   {24'd0, m_q});
        check("ack", {28'd0, ack}, {28'd0, m_ack});
        check("upd", {31'd0, upd}, {31'd0, m_upd});
        check("src", {30'd0, src}, m_src);
    endtask

    task automatic do_reset();
        res = 1'b1;
        tick();
        res = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_ptr = 0; m_ack = 4'b0000; m_q = INIT; m_src = 0; m_upd = 1'b0;
        last_grant = -1;
        res = 1'b1;
        req = 4'b0000;
        d   = 32'h0;

        // reset with arbitrary request/data activity, held for several edges
        for (int i = 0; i < 4; i++) begin
            req = 4'($urandom);
            d   = $urandom;
            tick();
            check("rst_q",   {24'd0, q},   32'h0000_00A5);
            check("rst_ack", {28'd0, ack}, 32'h0);
            check("rst_upd", {31'd0, upd}, 32'h0);
            check("rst_src", {30'd0, src}, 32'h0);
        end
        res = 1'b0;
        req = 4'b0000;
        tick();

        // single write from requester 2
        d = 32'h003C_0000;
        req = 4'b0100;
        tick();
        check("single_q",   {24'd0, q},   32'h3C);
        check("single_ack", {28'd0, ack}, 32'h4);
        check("single_upd", {31'd0, upd}, 32'h1);
        check("single_src", {30'd0, src}, 32'h2);
        tick();
        check("single_upd_drop", {31'd0, upd}, 32'h0);
        req = 4'b0000;
        tick();
        check("single_ack_rel", {28'd0, ack}, 32'h0);

        // full contention from ptr=0
        do_reset();
        d = 32'h1312_1110;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cont_q",   {24'd0, q},   32'h10 + i);
            check("cont_src", {30'd0, src}, i);
            check("cont_upd", {31'd0, upd}, 32'h1);
            check("cont_ack", {28'd0, ack}, (32'h1 << (i + 1)) - 1);
        end
        tick();
        check("cont_upd_end", {31'd0, upd}, 32'h0);
        req = 4'b0000;
        tick();

        // fairness: requester 0 cycles continuously while 3 is held high
        do_reset();
        d = 32'hD300_00A0;
        req = 4'b1001;
        tick();
        check("fair_first", {30'd0, src}, 32'h0);
        tick();
        check("fair_then3", {30'd0, src}, 32'h3);
        for (int t = 0; t < 12; t++) begin
            if (req[0] && ack[0]) req[0] = 1'b0;
            else if (!req[0] && !ack[0]) begin
                req[0] = 1'b1;
                d[7:0] = 8'($urandom);
            end else req[0] = req[0];
            tick();
        end
        req = 4'b0000;
        tick();
        tick();

        // withdrawal: req[1] raised with a grant to 0, dropped before its turn
        do_reset();
        d = 32'h0000_BB66;
        req = 4'b0011;
        tick();
        check("wd_grant0", {30'd0, src}, 32'h0);
        req = 4'b0001;
        tick();
        check("wd_q",    {24'd0, q},   32'h66);
        check("wd_upd",  {31'd0, upd}, 32'h0);
        check("wd_ack1", {31'd0, ack[1]}, 32'h0);
        req = 4'b0000;
        tick();

        // reset mid-transaction: 0 acknowledged and holding, 2 pending
        do_reset();
        d = 32'h0077_0055;
        req = 4'b0001;
        tick();
        check("mid_ack0", {28'd0, ack}, 32'h1);
        req = 4'b0101;
        res = 1'b1;
        tick();
        check("mid_rst_q", {24'd0, q}, 32'hA5);
        res = 1'b0;
        tick();
        check("mid_re0_q",   {24'd0, q},   32'h55);
        check("mid_re0_upd", {31'd0, upd}, 32'h1);
        tick();
        check("mid_re2_q",   {24'd0, q},   32'h77);
        check("mid_re2_upd", {31'd0, upd}, 32'h1);
        tick();
        check("mid_upd_end", {31'd0, upd}, 32'h0);
        req = 4'b0000;
        tick();

        // randomized protocol-obeying traffic
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack[i]) begin
                    if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
                    else req[i] = 1'b1;
                end else if (req[i] && !ack[i]) begin
                    if ($urandom_range(15, 0) == 0) req[i] = 1'b0;
                    else req[i] = 1'b1;
                end else if (!req[i] && !ack[i]) begin
                    if ($urandom_range(2, 0) == 0) begin
                        req[i] = 1'b1;
                        d[i*8 +: 8] = 8'($urandom);
                    end else req[i] = 1'b0;
                end else req[i] = 1'b0;
            end
            res = ($urandom_range(199, 0) == 0);
            tick();
            res = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
